// File: rtl/gpio_wr_arbiter.sv
// Round-robin arbiter for the shared 8-bit GPIO write port.
// A watchdog writes SAFE_VALUE after TIMEOUT cycles with no write.
module gpio_wr_arbiter #(
  parameter int unsigned TIMEOUT    = 50000,
  parameter logic [7:0]  SAFE_VALUE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic        gpio_wen,
  output logic [31:0] gpio_wdata,
  output logic        wd_fire,
  output logic [1:0]  last_src
);

  localparam bit          WD_EN = (TIMEOUT != 0);
  localparam logic [31:0] TERM  = TIMEOUT - 32'd1;

  localparam logic [1:0] SRC_REQ0 = 2'b01;
  localparam logic [1:0] SRC_REQ1 = 2'b10;
  localparam logic [1:0] SRC_WD   = 2'b11;

  logic        ptr_q, ptr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [7:0]  data_q, data_d;
  logic        fire_q, fire_d;
  logic [1:0]  src_q, src_d;

  logic gnt0, gnt1, acc, fire;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt0 = ~ptr_q;
      gnt1 = ptr_q;
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign acc        = gnt0 | gnt1;

  // A requester write in the terminal-count cycle suppresses the watchdog.
  assign fire = WD_EN && !acc && (cnt_q == TERM);

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q + 32'd1;
    wen_d  = acc | fire;
    fire_d = fire;
    data_d = data_q;
    src_d  = src_q;
    if (!WD_EN || acc || fire) begin
      cnt_d = '0;
    end
    unique case (1'b1)
      gnt0: begin
        ptr_d  = 1'b1;
        data_d = req0_data;
        src_d  = SRC_REQ0;
      end
      gnt1: begin
        ptr_d  = 1'b0;
        data_d = req1_data;
        src_d  = SRC_REQ1;
      end
      fire: begin
        data_d = SAFE_VALUE;
        src_d  = SRC_WD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= 1'b0;
      cnt_q  <= '0;
      wen_q  <= 1'b0;
      data_q <= '0;
      fire_q <= 1'b0;
      src_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      wen_q  <= wen_d;
      data_q <= data_d;
      fire_q <= fire_d;
      src_q  <= src_d;
    end
  end

  assign gpio_wen   = wen_q;
  assign gpio_wdata = {24'b0, data_q};
  assign wd_fire    = fire_q;
  assign last_src   = src_q;

endmodule
